ex_lsu_wbck: RTL and testbench

//  - Response-side stage directly downstream of the LSU arbiter/splitter.
//  - Consumes the merged ICB response (rdata, err, excl_ok plus the usr fields returned by the split FIFO).
//  - Routes back2agu responses straight to the AGU.
//  - All other responses get aligned load data, sign/zero extension and the SC result.
//  - These are queued in a small registered buffer that drives the LSU write-back/commit port.

---
 rtl/ex_lsu_wbck_pkg.sv | 15 +
 rtl/ex_lsu_wbck_fifo.sv | 77 +++++++
 rtl/ex_lsu_wbck.sv | 137 +++++++++++++
 tb/tb_ex_lsu_wbck.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_lsu_wbck_pkg.sv
// Shared widths and access-size encodings for the LSU write-back stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ex_lsu_wbck_pkg;

  localparam int E203_XLEN       = 32;
  localparam int E203_ADDR_SIZE  = 32;
  localparam int E203_ITAG_WIDTH = 1;

  // Access size encodings carried on i_rsp_size.
  localparam logic [1:0] LSU_SZ_B = 2'd0;
  localparam logic [1:0] LSU_SZ_H = 2'd1;
  localparam logic [1:0] LSU_SZ_W = 2'd2;

endpackage : ex_lsu_wbck_pkg

// File: rtl/ex_lsu_wbck_fifo.sv
// Generic DP x DW register FIFO, valid/ready on both sides, head entry driven from a register.
// Latency: 1 cycle from push to o_pop_vld when empty.
// Backpressure: o_push_rdy = ~full only; a pop in the same cycle does not free a slot early.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset (clears all entries to 0)
//   i_push_vld/o_push_rdy/_dat   write side
//   o_pop_vld/i_pop_rdy/_dat     read side (data is the head register)
//   o_cnt                        occupied entries
module ex_lsu_wbck_fifo #(
  parameter int DP = 2,
  parameter int DW = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push_vld,
  output logic                   o_push_rdy,
  input  logic [DW-1:0]          i_push_dat,
  output logic                   o_pop_vld,
  input  logic                   i_pop_rdy,
  output logic [DW-1:0]          o_pop_dat,
  output logic [$clog2(DP):0]    o_cnt
);

  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP) + 1;

  logic [DW-1:0] r_mem [DP];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Explicit wrap so non-power-of-2 depths (and DP=1) stay in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full  = (r_cnt == CW'(DP));
  assign w_empty = (r_cnt == '0);
  assign w_push  = i_push_vld & ~w_full;
  assign w_pop   = ~w_empty & i_pop_rdy;

  assign o_push_rdy = ~w_full;
  assign o_pop_vld  = ~w_empty;
  assign o_pop_dat  = r_mem[r_rptr];
  assign o_cnt      = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DP; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule : ex_lsu_wbck_fifo

// File: rtl/ex_lsu_wbck.sv
// LSU response stage: AGU responses pass straight through, others are formatted and buffered for write-back/commit.
// Latency: AGU path combinational; LSU path 1 cycle from accepted response to lsu_o_valid.
// Backpressure: AGU path ready = agu_rsp_ready; LSU path ready = ~buffer full (independent of lsu_o_ready).
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   i_rsp_*                merged ICB response plus split-FIFO user fields
//   agu_rsp_*              raw response back to the AGU (misaligned / AMO sequences)
//   lsu_o_*                write-back value and commit error info, from the buffer head
//   wbck_buf_cnt           occupied write-back buffer entries
module ex_lsu_wbck
  import ex_lsu_wbck_pkg::*;
#(
  parameter int XLEN   = E203_XLEN,
  parameter int AW     = E203_ADDR_SIZE,
  parameter int ITAG_W = E203_ITAG_WIDTH,
  parameter int DP     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rsp_valid,
  output logic                  i_rsp_ready,
  input  logic                  i_rsp_err,
  input  logic                  i_rsp_excl_ok,
  input  logic [XLEN-1:0]       i_rsp_rdata,
  input  logic                  i_rsp_back2agu,
  input  logic                  i_rsp_usign,
  input  logic                  i_rsp_read,
  input  logic [1:0]            i_rsp_size,
  input  logic [ITAG_W-1:0]     i_rsp_itag,
  input  logic [AW-1:0]         i_rsp_addr,
  input  logic                  i_rsp_excl,
  output logic                  agu_rsp_valid,
  input  logic                  agu_rsp_ready,
  output logic                  agu_rsp_err,
  output logic                  agu_rsp_excl_ok,
  output logic [XLEN-1:0]       agu_rsp_rdata,
  output logic                  lsu_o_valid,
  input  logic                  lsu_o_ready,
  output logic [XLEN-1:0]       lsu_o_wbck_wdat,
  output logic [ITAG_W-1:0]     lsu_o_wbck_itag,
  output logic                  lsu_o_wbck_err,
  output logic                  lsu_o_cmt_ld,
  output logic                  lsu_o_cmt_st,
  output logic                  lsu_o_cmt_buserr,
  output logic [AW-1:0]         lsu_o_cmt_badaddr,
  output logic [$clog2(DP):0]   wbck_buf_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]   wdat;
    logic [ITAG_W-1:0] itag;
    logic              ld;
    logic              st;
    logic              buserr;
    logic [AW-1:0]     badaddr;
  } ent_t;

  localparam int EW = $bits(ent_t);

  // Bring the addressed lane down to bit 0, then truncate and extend by size.
  // Size 3 is not a legal encoding and falls through to word.
  function automatic logic [XLEN-1:0] fmt_load(
    input logic [XLEN-1:0] rdata,
    input logic [1:0]      ofs,
    input logic [1:0]      size,
    input logic            usign
  );
    logic [XLEN-1:0] sh;
    sh = rdata >> {ofs, 3'b000};
    case (size)
      LSU_SZ_B: return {{(XLEN-8){~usign & sh[7]}}, sh[7:0]};
      LSU_SZ_H: return {{(XLEN-16){~usign & sh[15]}}, sh[15:0]};
      default:  return sh;
    endcase
  endfunction

  logic       w_agu_sel;
  logic       w_push_vld;
  logic       w_push_rdy;
  ent_t       w_push_ent;
  logic [EW-1:0] w_pop_dat;
  ent_t       w_head;

  assign w_agu_sel = i_rsp_valid & i_rsp_back2agu;

  // AGU path: raw data, gated so it reads 0 whenever it is not an AGU response.
  assign agu_rsp_valid   = w_agu_sel;
  assign agu_rsp_err     = w_agu_sel & i_rsp_err;
  assign agu_rsp_excl_ok = w_agu_sel & i_rsp_excl_ok;
  assign agu_rsp_rdata   = w_agu_sel ? i_rsp_rdata : '0;

  assign i_rsp_ready = i_rsp_back2agu ? agu_rsp_ready : w_push_rdy;
  assign w_push_vld  = i_rsp_valid & ~i_rsp_back2agu;

  always_comb begin
    w_push_ent         = '0;
    w_push_ent.itag    = i_rsp_itag;
    if (i_rsp_err) begin
      // Faulting access: no rd value, report the address to commit.
      w_push_ent.buserr  = 1'b1;
      w_push_ent.badaddr = i_rsp_addr;
      w_push_ent.ld      = i_rsp_read;
      w_push_ent.st      = ~i_rsp_read;
    end else if (i_rsp_read) begin
      w_push_ent.wdat = fmt_load(i_rsp_rdata, i_rsp_addr[1:0], i_rsp_size, i_rsp_usign);
    end else if (i_rsp_excl) begin
      // SC writes 0 to rd on success, 1 on failure.
      w_push_ent.wdat = {{(XLEN-1){1'b0}}, ~i_rsp_excl_ok};
    end
  end

  ex_lsu_wbck_fifo #(
    .DP (DP),
    .DW (EW)
  ) u_wbck_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (w_push_vld),
    .o_push_rdy (w_push_rdy),
    .i_push_dat (w_push_ent),
    .o_pop_vld  (lsu_o_valid),
    .i_pop_rdy  (lsu_o_ready),
    .o_pop_dat  (w_pop_dat),
    .o_cnt      (wbck_buf_cnt)
  );

  assign w_head            = ent_t'(w_pop_dat);
  assign lsu_o_wbck_wdat   = w_head.wdat;
  assign lsu_o_wbck_itag   = w_head.itag;
  assign lsu_o_wbck_err    = w_head.buserr;
  assign lsu_o_cmt_ld      = w_head.ld;
  assign lsu_o_cmt_st      = w_head.st;
  assign lsu_o_cmt_buserr  = w_head.buserr;
  assign lsu_o_cmt_badaddr = w_head.badaddr;

endmodule : ex_lsu_wbck

// File: tb/tb_ex_lsu_wbck.sv
// Self-checking bench for ex_lsu_wbck: vector table through a scoreboard plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: exercised via lsu_o_ready / agu_rsp_ready.
module tb_ex_lsu_wbck;

  logic        clk;
  logic        rst_n;
  logic        i_rsp_valid;
  logic        i_rsp_ready;
  logic        i_rsp_err;
  logic        i_rsp_excl_ok;
  logic [31:0] i_rsp_rdata;
  logic        i_rsp_back2agu;
  logic        i_rsp_usign;
  logic        i_rsp_read;
  logic [1:0]  i_rsp_size;
  logic [0:0]  i_rsp_itag;
  logic [31:0] i_rsp_addr;
  logic        i_rsp_excl;
  logic        agu_rsp_valid;
  logic        agu_rsp_ready;
  logic        agu_rsp_err;
  logic        agu_rsp_excl_ok;
  logic [31:0] agu_rsp_rdata;
  logic        lsu_o_valid;
  logic        lsu_o_ready;
  logic [31:0] lsu_o_wbck_wdat;
  logic [0:0]  lsu_o_wbck_itag;
  logic        lsu_o_wbck_err;
  logic        lsu_o_cmt_ld;
  logic        lsu_o_cmt_st;
  logic        lsu_o_cmt_buserr;
  logic [31:0] lsu_o_cmt_badaddr;
  logic [1:0]  wbck_buf_cnt;

  ex_lsu_wbck dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_rsp_valid       (i_rsp_valid),
    .i_rsp_ready       (i_rsp_ready),
    .i_rsp_err         (i_rsp_err),
    .i_rsp_excl_ok     (i_rsp_excl_ok),
    .i_rsp_rdata       (i_rsp_rdata),
    .i_rsp_back2agu    (i_rsp_back2agu),
    .i_rsp_usign       (i_rsp_usign),
    .i_rsp_read        (i_rsp_read),
    .i_rsp_size        (i_rsp_size),
    .i_rsp_itag        (i_rsp_itag),
    .i_rsp_addr        (i_rsp_addr),
    .i_rsp_excl        (i_rsp_excl),
    .agu_rsp_valid     (agu_rsp_valid),
    .agu_rsp_ready     (agu_rsp_ready),
    .agu_rsp_err       (agu_rsp_err),
    .agu_rsp_excl_ok   (agu_rsp_excl_ok),
    .agu_rsp_rdata     (agu_rsp_rdata),
    .lsu_o_valid       (lsu_o_valid),
    .lsu_o_ready       (lsu_o_ready),
    .lsu_o_wbck_wdat   (lsu_o_wbck_wdat),
    .lsu_o_wbck_itag   (lsu_o_wbck_itag),
    .lsu_o_wbck_err    (lsu_o_wbck_err),
    .lsu_o_cmt_ld      (lsu_o_cmt_ld),
    .lsu_o_cmt_st      (lsu_o_cmt_st),
    .lsu_o_cmt_buserr  (lsu_o_cmt_buserr),
    .lsu_o_cmt_badaddr (lsu_o_cmt_badaddr),
    .wbck_buf_cnt      (wbck_buf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, us, ex, exok, err;
    logic [1:0]  sz;
    logic [31:0] addr, rdata;
    logic        itag;
    logic [31:0] e_wdat;
    logic        e_ld, e_st, e_be;
    logic [31:0] e_bad;
  } vec_t;

  typedef struct {
    logic [31:0] wdat;
    logic        itag, ld, st, be;
    logic [31:0] bad;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic mon_en = 1'b0;
  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic rd, us, ex, exok, err, input logic [1:0] sz,
                              input logic [31:0] addr, rdata, input logic itag,
                              input logic [31:0] e_wdat, input logic e_ld, e_st, e_be,
                              input logic [31:0] e_bad);
    vec_t v;
    v.rd = rd; v.us = us; v.ex = ex; v.exok = exok; v.err = err; v.sz = sz;
    v.addr = addr; v.rdata = rdata; v.itag = itag;
    v.e_wdat = e_wdat; v.e_ld = e_ld; v.e_st = e_st; v.e_be = e_be; v.e_bad = e_bad;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    i_rsp_valid    = 1'b1;
    i_rsp_back2agu = 1'b0;
    i_rsp_read     = v.rd;
    i_rsp_usign    = v.us;
    i_rsp_excl     = v.ex;
    i_rsp_excl_ok  = v.exok;
    i_rsp_err      = v.err;
    i_rsp_size     = v.sz;
    i_rsp_addr     = v.addr;
    i_rsp_rdata    = v.rdata;
    i_rsp_itag     = v.itag;
  endtask

  // Called at posedge+1; returns at posedge+1 after the response is accepted.
  task automatic send(input vec_t v);
    exp_t e;
    bit   ok = 0;
    drive(v);
    e.wdat = v.e_wdat; e.itag = v.itag; e.ld = v.e_ld; e.st = v.e_st;
    e.be = v.e_be; e.bad = v.e_bad;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i_rsp_ready) begin
        ok = 1;
        exp_q.push_back(e);
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    i_rsp_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Scoreboard: compare the head whenever a pop handshake is about to complete.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && lsu_o_valid && lsu_o_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pop", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_wdat",    lsu_o_wbck_wdat,   e.wdat);
          chk("sb_itag",    lsu_o_wbck_itag,   32'(e.itag));
          chk("sb_err",     lsu_o_wbck_err,    32'(e.be));
          chk("sb_buserr",  lsu_o_cmt_buserr,  32'(e.be));
          chk("sb_cmt_ld",  lsu_o_cmt_ld,      32'(e.ld));
          chk("sb_cmt_st",  lsu_o_cmt_st,      32'(e.st));
          chk("sb_badaddr", lsu_o_cmt_badaddr, e.bad);
        end
      end
    end
  end

  initial begin
    //            rd us ex ok er sz  addr          rdata         it  wdat          ld st be bad
    vt[0]  = mk(1, 0, 0, 0, 0, 2'd0, 32'h0000_0003, 32'h80AA_5511, 1, 32'hFFFF_FF80, 0, 0, 0, 32'h0);
    vt[1]  = mk(1, 1, 0, 0, 0, 2'd1, 32'h0000_0002, 32'h8001_1234, 0, 32'h0000_8001, 0, 0, 0, 32'h0);
    vt[2]  = mk(0, 0, 1, 1, 0, 2'd2, 32'h0000_0040, 32'h5555_5555, 1, 32'h0000_0000, 0, 0, 0, 32'h0);
    vt[3]  = mk(0, 0, 1, 0, 0, 2'd2, 32'h0000_0040, 32'h5555_5555, 0, 32'h0000_0001, 0, 0, 0, 32'h0);
    vt[4]  = mk(0, 0, 0, 0, 1, 2'd2, 32'h2000_0010, 32'h1234_5678, 1, 32'h0000_0000, 0, 1, 1, 32'h2000_0010);
    vt[5]  = mk(1, 0, 0, 0, 0, 2'd2, 32'h0000_0000, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h0);
    vt[6]  = mk(1, 1, 0, 0, 0, 2'd0, 32'h0000_0001, 32'h1234_F600, 1, 32'h0000_00F6, 0, 0, 0, 32'h0);
    vt[7]  = mk(1, 0, 0, 0, 0, 2'd1, 32'h0000_0000, 32'h0000_8765, 0, 32'hFFFF_8765, 0, 0, 0, 32'h0);
    vt[8]  = mk(1, 0, 0, 0, 1, 2'd2, 32'h1000_0004, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1, 0, 1, 32'h1000_0004);
    vt[9]  = mk(1, 0, 0, 0, 0, 2'd3, 32'h0000_0000, 32'h1357_9BDF, 0, 32'h1357_9BDF, 0, 0, 0, 32'h0);
    vt[10] = mk(0, 0, 0, 1, 0, 2'd2, 32'h0000_0008, 32'hFFFF_FFFF, 1, 32'h0000_0000, 0, 0, 0, 32'h0);
    vt[11] = mk(1, 0, 0, 0, 0, 2'd0, 32'h0000_0002, 32'h007F_0000, 0, 32'h0000_007F, 0, 0, 0, 32'h0);

    rst_n = 1'b0;
    i_rsp_valid = 1'b0; i_rsp_err = 1'b0; i_rsp_excl_ok = 1'b0; i_rsp_rdata = '0;
    i_rsp_back2agu = 1'b0; i_rsp_usign = 1'b0; i_rsp_read = 1'b0; i_rsp_size = '0;
    i_rsp_itag = '0; i_rsp_addr = '0; i_rsp_excl = 1'b0;
    agu_rsp_ready = 1'b1; lsu_o_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",   lsu_o_valid,       32'd0);
    chk("rst_cnt",     wbck_buf_cnt,      32'd0);
    chk("rst_wdat",    lsu_o_wbck_wdat,   32'd0);
    chk("rst_badaddr", lsu_o_cmt_badaddr, 32'd0);
    chk("rst_agu_vld", agu_rsp_valid,     32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", i_rsp_ready, 32'd1);
    mon_en = 1'b1;

    // Table vectors: each entry visible the cycle after acceptance.
    for (int i = 0; i < 12; i++) begin
      send(vt[i]);
      chk("lat_valid", lsu_o_valid,  32'd1);
      chk("lat_cnt",   wbck_buf_cnt, 32'd1);
    end
    drain();

    // Fill with the sink stalled, check full/hold behaviour, then drain in order.
    lsu_o_ready = 1'b0;
    send(mk(1, 0, 0, 0, 0, 2'd2, 32'h0, 32'h1111_1111, 1, 32'h1111_1111, 0, 0, 0, 32'h0));
    send(mk(1, 1, 0, 0, 0, 2'd0, 32'h3, 32'hAB00_0000, 0, 32'h0000_00AB, 0, 0, 0, 32'h0));
    drive(mk(1, 1, 0, 0, 0, 2'd1, 32'h0, 32'h0000_BEEF, 1, 32'h0000_BEEF, 0, 0, 0, 32'h0));
    @(negedge clk);
    chk("full_ready", i_rsp_ready,     32'd0);
    chk("full_cnt",   wbck_buf_cnt,    32'd2);
    chk("head_itag",  lsu_o_wbck_itag, 32'd1);
    chk("head_wdat",  lsu_o_wbck_wdat, 32'h1111_1111);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_wdat",  lsu_o_wbck_wdat, 32'h1111_1111);
    chk("hold_cnt",   wbck_buf_cnt,    32'd2);
    @(posedge clk); #1;
    lsu_o_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_ready", i_rsp_ready, 32'd0);
    @(posedge clk); #1;
    send(mk(1, 1, 0, 0, 0, 2'd1, 32'h0, 32'h0000_BEEF, 1, 32'h0000_BEEF, 0, 0, 0, 32'h0));
    drain();

    // AGU pass-through with AGU back-pressure; buffer must stay untouched.
    i_rsp_valid = 1'b1; i_rsp_back2agu = 1'b1; i_rsp_err = 1'b1; i_rsp_excl_ok = 1'b1;
    i_rsp_rdata = 32'hCAFE_F00D; i_rsp_read = 1'b1; agu_rsp_ready = 1'b0;
    @(negedge clk);
    chk("agu_ready_low", i_rsp_ready,     32'd0);
    chk("agu_valid",     agu_rsp_valid,   32'd1);
    chk("agu_rdata",     agu_rsp_rdata,   32'hCAFE_F00D);
    chk("agu_err",       agu_rsp_err,     32'd1);
    chk("agu_excl_ok",   agu_rsp_excl_ok, 32'd1);
    @(posedge clk); #1;
    chk("agu_cnt",       wbck_buf_cnt,    32'd0);
    agu_rsp_ready = 1'b1;
    @(negedge clk);
    chk("agu_ready_high", i_rsp_ready,    32'd1);
    @(posedge clk); #1;
    chk("agu_cnt2",      wbck_buf_cnt,    32'd0);
    chk("agu_lsu_vld",   lsu_o_valid,     32'd0);
    i_rsp_valid = 1'b0; i_rsp_back2agu = 1'b0; i_rsp_err = 1'b0;
    #1;
    chk("agu_idle",      agu_rsp_valid,   32'd0);

    // Reset mid-traffic drops all entries at once.
    @(posedge clk); #1;
    lsu_o_ready = 1'b0;
    send(vt[5]);
    send(vt[6]);
    chk("pre_rst_cnt", wbck_buf_cnt, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", lsu_o_valid,     32'd0);
    chk("mid_rst_cnt",   wbck_buf_cnt,    32'd0);
    chk("mid_rst_wdat",  lsu_o_wbck_wdat, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    lsu_o_ready = 1'b1;
    @(posedge clk); #1;
    send(vt[1]);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ex_lsu_wbck
